// File: rtl/lru_if.sv
// Request/victim bus between the cache tag logic and the pseudo-LRU tracker.
// valid_i qualifies hit_i/idx_i every cycle. There is no ready: the tracker takes every request, and the consumer must take valid_o/idx_o in the cycle valid_o is high.
interface lru_if #(
   parameter int IDX_W = 10
);
   logic             hit_i;
   logic             valid_i;
   logic [IDX_W-1:0] idx_i;
   logic             valid_o;
   logic [IDX_W-1:0] idx_o;

   modport slave  (input  hit_i, valid_i, idx_i, output valid_o, idx_o);
   modport master (output hit_i, valid_i, idx_i, input  valid_o, idx_o);
endinterface

// File: rtl/lru.sv
// Tree pseudo-LRU tracker. A hit marks its line MRU. A miss returns a registered victim, and that victim is marked MRU on the same edge.
module lru #(
   parameter int IDX_W = 10
) (
   input logic  clk_i,
   input logic  rst_ni,
   lru_if.slave bus
);
   localparam int NODES = (1 << IDX_W) - 1;

   logic [NODES-1:0] tree_q, tree_d;
   logic             valid_q, valid_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] victim;
   logic [IDX_W-1:0] touch_idx;
   logic             miss;

   // Heap order: node n has children 2n+1 and 2n+2. Past the leaf level the value wraps, but it is never used.
   function automatic logic [IDX_W-1:0] child(input logic [IDX_W-1:0] node, input logic b);
      return {node[IDX_W-2:0], 1'b1} + {{(IDX_W-1){1'b0}}, b};
   endfunction

   assign miss = bus.valid_i & ~bus.hit_i;

   always_comb begin
      logic [IDX_W-1:0] node;
      logic             b;
      victim = '0;
      node   = '0;
      b      = 1'b0;
      for (int k = 0; k < IDX_W; k++) begin
         b      = tree_q[node];
         victim = {victim[IDX_W-2:0], b};
         node   = child(node, b);
      end
   end

   assign touch_idx = bus.hit_i ? bus.idx_i : victim;

   always_comb begin
      logic [IDX_W-1:0] node;
      logic [IDX_W-1:0] path;
      logic             b;
      tree_d = tree_q;
      node   = '0;
      path   = touch_idx;
      b      = 1'b0;
      if (bus.valid_i) begin
         // Each node on the path is set to point away from the touched line.
         for (int k = 0; k < IDX_W; k++) begin
            b            = path[IDX_W-1];
            tree_d[node] = ~b;
            node         = child(node, b);
            path         = path << 1;
         end
      end
   end

   always_comb begin
      valid_d = miss;
      idx_d   = miss ? victim : idx_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tree_q  <= '0;
         valid_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         tree_q  <= tree_d;
         valid_q <= valid_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.valid_o = valid_q;
   assign bus.idx_o   = idx_q;
endmodule

// File: tb/tb_lru.sv
// Bench for lru: directed vector table, async-reset sequence, and random stream against a prefix-keyed PLRU model.
module tb_lru;
   localparam int W = 10;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   passed = 0;

   lru_if #(.IDX_W(W)) bus ();

   lru #(.IDX_W(W)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // One direction bit per (level, index prefix): 1 means the LRU side is the upper half.
   bit model_dir [W][1 << W];
   logic [W-1:0] exp_q [$];

   function automatic void model_reset();
      for (int k = 0; k < W; k++)
         for (int p = 0; p < (1 << W); p++)
            model_dir[k][p] = 1'b0;
   endfunction

   function automatic int model_victim();
      int v = 0;
      for (int k = 0; k < W; k++) v = (v << 1) | int'(model_dir[k][v]);
      return v;
   endfunction

   function automatic void model_touch(input int i);
      for (int k = 0; k < W; k++) model_dir[k][i >> (W - k)] = !((i >> (W - 1 - k)) & 1);
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic chk_ne(input string name, input int act, input int not_exp);
      checks++;
      if (act != not_exp) passed++;
      else $display("FAIL %s: got %0d, must differ from %0d", name, act, not_exp);
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      bus.valid_i = 1'b0;
      bus.hit_i   = 1'b0;
      bus.idx_i   = '0;
      rst_n       = 1'b0;
      model_reset();
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Drive one request, let one rising edge take it, sample 1 time unit later.
   task automatic step(input logic v, input logic h, input logic [W-1:0] i);
      bus.valid_i = v;
      bus.hit_i   = h;
      bus.idx_i   = i;
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit         rst;
      logic       valid;
      logic       hit;
      logic [W-1:0] idx;
      logic       exp_valid;
      logic [W-1:0] exp_idx;
   } vec_t;

   vec_t vecs [$];

   function automatic void add(input bit r, input logic v, input logic h, input int i,
                               input logic ev, input int ei);
      vec_t t;
      t.rst = r; t.valid = v; t.hit = h; t.idx = W'(i);
      t.exp_valid = ev; t.exp_idx = W'(ei);
      vecs.push_back(t);
   endfunction

   initial begin
      int last_touch;
      bit have_touch;
      logic [W-1:0] hold_idx;

      rst_n       = 1'b0;
      bus.valid_i = 1'b0;
      bus.hit_i   = 1'b0;
      bus.idx_i   = '0;
      #2;
      chk("reset valid_o", int'(bus.valid_o), 0);
      chk("reset idx_o", int'(bus.idx_o), 0);

      // Single miss, then idle.
      add(1, 1, 0, 0,   1, 0);
      add(0, 0, 0, 0,   0, 0);
      // Three back-to-back misses.
      add(1, 1, 0, 0,   1, 0);
      add(0, 1, 0, 0,   1, 512);
      add(0, 1, 0, 0,   1, 256);
      add(0, 0, 0, 0,   0, 256);
      // Hits 0,1,3,7,3 then miss; hit 512 then miss.
      add(1, 1, 1, 0,   0, 0);
      add(0, 1, 1, 1,   0, 0);
      add(0, 1, 1, 3,   0, 0);
      add(0, 1, 1, 7,   0, 0);
      add(0, 1, 1, 3,   0, 0);
      add(0, 1, 0, 0,   1, 512);
      add(0, 1, 1, 512, 0, 512);
      add(0, 1, 0, 0,   1, 256);
      // Unqualified hits leave the tree alone.
      add(1, 0, 1, 5,   0, 0);
      add(0, 0, 1, 5,   0, 0);
      add(0, 1, 0, 0,   1, 0);

      foreach (vecs[n]) begin
         if (vecs[n].rst) do_reset();
         step(vecs[n].valid, vecs[n].hit, vecs[n].idx);
         chk($sformatf("vec%0d valid_o", n), int'(bus.valid_o), int'(vecs[n].exp_valid));
         chk($sformatf("vec%0d idx_o", n), int'(bus.idx_o), int'(vecs[n].exp_idx));
      end

      // Asynchronous reset between misses clears outputs without waiting for a clock edge.
      do_reset();
      step(1, 0, '0);
      chk("async seq victim0", int'(bus.idx_o), 0);
      step(1, 0, '0);
      chk("async seq victim1", int'(bus.idx_o), 512);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async valid_o cleared", int'(bus.valid_o), 0);
      chk("async idx_o cleared", int'(bus.idx_o), 0);
      bus.valid_i = 1'b0;
      #1;
      rst_n = 1'b1;
      step(1, 0, '0);
      chk("post-reset valid_o", int'(bus.valid_o), 1);
      chk("post-reset victim", int'(bus.idx_o), 0);

      // ---------------- random stream against the model ----------------
      do_reset();
      have_touch = 1'b0;
      last_touch = 0;
      hold_idx   = '0;
      for (int n = 0; n < 3000; n++) begin
         logic v, h;
         logic [W-1:0] i;
         int prev_touch;
         bit prev_have;
         v = ($urandom_range(0, 99) < 90);
         h = ($urandom_range(0, 99) < 55);
         i = ($urandom_range(0, 3) == 0) ? hold_idx : W'($urandom_range(0, (1 << W) - 1));
         prev_touch = last_touch;
         prev_have  = have_touch;
         if (v && !h) begin
            int ev;
            ev = model_victim();
            exp_q.push_back(W'(ev));
            model_touch(ev);
            last_touch = ev;
            have_touch = 1'b1;
            hold_idx   = W'(ev);
         end else if (v && h) begin
            model_touch(int'(i));
            last_touch = int'(i);
            have_touch = 1'b1;
         end
         step(v, h, i);
         chk("rand valid_o", int'(bus.valid_o), int'(v && !h));
         if (bus.valid_o) begin
            if (exp_q.size() == 0) begin
               chk("rand unexpected victim", 1, 0);
            end else begin
               logic [W-1:0] e;
               e = exp_q.pop_front();
               chk("rand victim", int'(bus.idx_o), int'(e));
            end
            if (prev_have) chk_ne("rand victim vs last touched", int'(bus.idx_o), prev_touch);
         end else begin
            chk("rand idx_o hold", int'(bus.idx_o), int'(hold_idx));
         end
      end
      chk("rand queue drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/lru.md
# lru

Tree pseudo-LRU replacement tracker for a cache of 2^IDX_W lines (1024 by default). It sits beside the cache tag array. Every access is reported to it: a hit marks that line most recently used, and a miss is answered with a registered victim index for the refill. One request per cycle; no stall.

## Interface
- IDX_W, default 10: width of a line index; the tracker covers ENTRIES = 2^IDX_W lines.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- hit_i  input  1  qualifier for the request: 1 = hit on idx_i, 0 = miss (victim wanted).
- valid_i  input  1  request strobe; no state change when 0.
- idx_i  input  IDX_W  index of the line hit; ignored on a miss.
- valid_o  output  1  victim valid; one-cycle pulse per miss.
- idx_o  output  IDX_W  victim line index; meaningful only while valid_o=1.

## Operation
- State is an ENTRIES-1 bit binary tree held in heap order:
  - root is node 0; node n has children 2n+1 and 2n+2.
  - Level k (root = level 0) is steered by index bit IDX_W-1-k.
- Node bit semantics: 0 = LRU side is left (lower indices); 1 = LRU side is right.
- Touch(i): for each level k, the node on i's path is set to the complement of bit IDX_W-1-k of i. Every node on the path then points away from i. Nodes off the path are unchanged.
- Victim walk: start at the root. At each level take the branch given by the node bit; that bit becomes the next victim bit, MSB first.
- valid_i=1, hit_i=1: Touch(idx_i). Next cycle: valid_o=0, idx_o holds its previous value.
- valid_i=1, hit_i=0:
  - Compute victim v from the current tree.
  - Register idx_o<=v and valid_o<=1.
  - Touch(v) in the same edge; the refilled line becomes MRU.
- valid_i=0: tree unchanged; valid_o<=0; idx_o holds.
- Reset (asynchronous, any time, including mid-sequence): all tree bits 0, valid_o=0, idx_o=0. First victim after reset is index 0.

## Timing
- Hit update latency is 1 cycle: a request at edge t affects the victim computed for a request at edge t+1.
- Miss latency is 1 cycle: a miss sampled at edge t gives valid_o=1 and idx_o=v after edge t. valid_o drops after edge t+1 unless another miss is sampled.
- Back-to-back misses return distinct victims, because each victim is touched as it is issued.
- No handshake back-pressure; the consumer must accept valid_o in the cycle it is high.
- Victim computation is combinational over IDX_W tree levels. Tree and outputs are flops.
- Reset release is synchronous-safe: the first request is sampled on the first rising edge after rst_ni goes high.

## Test plan
- Reset, then one miss → next cycle valid_o=1, idx_o=0; the following idle cycle gives valid_o=0.
- After reset, three consecutive misses → idx_o sequence is 0, 512, 256, with valid_o high for 3 cycles.
- After reset, hits on 0, 1, 3, 7, 3 back-to-back, then a miss:
  - valid_o stays 0 during all hits;
  - the miss gives idx_o=512.
  - Then hit 512, then miss → idx_o=256.
- Hits with valid_i=0 (hit_i=1, idx_i=5) followed by a miss → idx_o=0; tree unchanged by the unqualified cycles.
- Assert rst_ni low between two misses (after victim 0) → valid_o and idx_o go 0 immediately. The next miss after release returns 0 again.
- Random hit/miss stream compared against a reference tree-PLRU model:
  - check every idx_o;
  - check that no victim equals the most recently touched index.
